// File: rtl/control_lectura_if.sv
// Handshake and data bundle between the barcode read controller and its host/serial source.
interface control_lectura_if;
  logic        START;
  logic        SDI;
  logic        SVALID;
  logic        ACK;
  logic [11:0] L;
  logic        EN;
  logic        RCLR;
  logic        BUSY;
  logic        DONE;
  logic        ERR;
  logic [3:0]  CNT;

  modport master (
    output START, SDI, SVALID, ACK,
    input  L, EN, RCLR, BUSY, DONE, ERR, CNT
  );

  modport slave (
    input  START, SDI, SVALID, ACK,
    output L, EN, RCLR, BUSY, DONE, ERR, CNT
  );
endinterface

// File: rtl/control_lectura.sv
// Serial barcode reader: shifts in a 12-bit word MSB first, validates day/month,
// and pulses a load enable to the word register, or a clear pulse on error.
module control_lectura #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              CLR,
  control_lectura_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    CHECK,
    LOAD,
    WAIT_ACK
  } state_t;

  state_t      state_q;
  logic [11:0] shreg_q;
  logic [3:0]  cnt_q;
  logic [7:0]  timer_q;
  logic        en_q;
  logic        rclr_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;

  logic [4:0]  day;
  logic [3:0]  month;
  logic        word_ok;
  logic        timer_hit;

  assign day       = shreg_q[4:0];
  assign month     = shreg_q[8:5];
  assign word_ok   = (day != 5'd0) && (month != 4'd0) && (month <= 4'd12);
  assign timer_hit = ({1'b0, timer_q} + 9'd1) == 9'(TIMEOUT);

  // Outputs are registered: each flag is set on the edge that enters the state
  // it belongs to, so EN/RCLR/DONE/BUSY line up exactly with the state register.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      timer_q <= '0;
      en_q    <= 1'b0;
      rclr_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      en_q   <= 1'b0;
      rclr_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (bus.START) begin
            state_q <= SHIFT;
            shreg_q <= '0;
            cnt_q   <= '0;
            timer_q <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        SHIFT: begin
          if (bus.SVALID) begin
            shreg_q <= {shreg_q[10:0], bus.SDI};
            cnt_q   <= cnt_q + 4'd1;
            timer_q <= '0;
            if (cnt_q == 4'd11) begin
              state_q <= CHECK;
            end
          end else if (timer_hit) begin
            state_q <= IDLE;
            err_q   <= 1'b1;
            rclr_q  <= 1'b0;
            busy_q  <= 1'b0;
          end else begin
            timer_q <= timer_q + 8'd1;
          end
        end
        CHECK: begin
          if (word_ok) begin
            state_q <= LOAD;
            en_q    <= 1'b1;
          end else begin
            state_q <= IDLE;
            err_q   <= 1'b1;
            rclr_q  <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        LOAD: begin
          state_q <= WAIT_ACK;
          done_q  <= 1'b1;
        end
        WAIT_ACK: begin
          if (bus.ACK) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.L    = shreg_q;
  assign bus.EN   = en_q;
  assign bus.RCLR = rclr_q;
  assign bus.BUSY = busy_q;
  assign bus.DONE = done_q;
  assign bus.ERR  = err_q;
  assign bus.CNT  = cnt_q;

endmodule

// File: tb/tb_control_lectura.sv
// Scoreboard bench for control_lectura: stimulus queues expected EN/RCLR events,
// a negedge monitor pops and checks them; directed checks cover timing and flags.
module tb_control_lectura;

  logic CLK;
  logic CLR;

  control_lectura_if bus ();

  control_lectura #(.TIMEOUT(4)) dut (
    .CLK (CLK),
    .CLR (CLR),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int          kind;   // 0 = load (EN pulse), 1 = error (RCLR low)
    logic [11:0] word;
    logic        err;
  } ev_t;

  ev_t sb[$];
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (CLR && (bus.EN || !bus.RCLR)) begin
      chk("en_rclr_exclusive", {31'd0, bus.EN & ~bus.RCLR}, 32'd0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got EN=%0b RCLR=%0b L=0x%0h expected no event at %0t",
                 bus.EN, bus.RCLR, bus.L, $time);
      end else begin
        ev_t e;
        e = sb.pop_front();
        chk("event_kind", bus.EN ? 32'd0 : 32'd1, e.kind);
        chk("event_L", {20'd0, bus.L}, {20'd0, e.word});
        chk("event_ERR", {31'd0, bus.ERR}, {31'd0, e.err});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic pulse_start();
    bus.START = 1'b1;
    @(posedge CLK); #1;
    bus.START = 1'b0;
  endtask

  task automatic send_bits(input logic [11:0] w, input int unsigned n, input int unsigned gap);
    for (int unsigned i = 0; i < n; i++) begin
      bus.SDI    = w[11 - i];
      bus.SVALID = 1'b1;
      @(posedge CLK); #1;
      bus.SVALID = 1'b0;
      bus.SDI    = 1'b0;
      if (i != n - 1) begin
        repeat (gap) begin
          @(posedge CLK); #1;
        end
      end
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_L"},    {20'd0, bus.L}, 32'd0);
    chk({tag, "_EN"},   {31'd0, bus.EN}, 32'd0);
    chk({tag, "_RCLR"}, {31'd0, bus.RCLR}, 32'd1);
    chk({tag, "_BUSY"}, {31'd0, bus.BUSY}, 32'd0);
    chk({tag, "_DONE"}, {31'd0, bus.DONE}, 32'd0);
    chk({tag, "_ERR"},  {31'd0, bus.ERR}, 32'd0);
    chk({tag, "_CNT"},  {28'd0, bus.CNT}, 32'd0);
  endtask

  // Full good read with latency checks; ack_start drives ACK and START together.
  task automatic read_ok(input logic [11:0] w, input int unsigned gap, input bit ack_start);
    pulse_start();
    @(negedge CLK);
    chk("start_BUSY", {31'd0, bus.BUSY}, 32'd1);
    chk("start_CNT", {28'd0, bus.CNT}, 32'd0);
    sb.push_back('{kind: 0, word: w, err: 1'b0});
    @(posedge CLK); #1;
    send_bits(w, 12, gap);
    @(negedge CLK);
    chk("check_EN", {31'd0, bus.EN}, 32'd0);
    chk("check_CNT", {28'd0, bus.CNT}, 32'd12);
    chk("check_L", {20'd0, bus.L}, {20'd0, w});
    @(negedge CLK);
    chk("load_EN", {31'd0, bus.EN}, 32'd1);
    chk("load_DONE", {31'd0, bus.DONE}, 32'd0);
    @(negedge CLK);
    chk("wait_DONE", {31'd0, bus.DONE}, 32'd1);
    chk("wait_EN", {31'd0, bus.EN}, 32'd0);
    bus.START  = 1'b1;
    bus.SVALID = 1'b1;
    @(negedge CLK);
    bus.START  = 1'b0;
    bus.SVALID = 1'b0;
    chk("ignored_DONE", {31'd0, bus.DONE}, 32'd1);
    chk("ignored_L", {20'd0, bus.L}, {20'd0, w});
    chk("ignored_ERR", {31'd0, bus.ERR}, 32'd0);
    bus.ACK   = 1'b1;
    bus.START = ack_start;
    @(posedge CLK); #1;
    bus.ACK   = 1'b0;
    bus.START = 1'b0;
    @(negedge CLK);
    chk("ack_DONE", {31'd0, bus.DONE}, 32'd0);
    chk("ack_BUSY", {31'd0, bus.BUSY}, 32'd0);
    if (ack_start) begin
      repeat (3) @(negedge CLK);
      chk("ackstart_no_read_BUSY", {31'd0, bus.BUSY}, 32'd0);
    end
  endtask

  task automatic read_bad(input logic [11:0] w);
    pulse_start();
    sb.push_back('{kind: 1, word: w, err: 1'b1});
    send_bits(w, 12, 0);
    @(negedge CLK);
    chk("bad_check_RCLR", {31'd0, bus.RCLR}, 32'd1);
    @(negedge CLK);
    chk("bad_RCLR", {31'd0, bus.RCLR}, 32'd0);
    chk("bad_ERR", {31'd0, bus.ERR}, 32'd1);
    chk("bad_BUSY", {31'd0, bus.BUSY}, 32'd0);
    @(negedge CLK);
    chk("bad_RCLR_release", {31'd0, bus.RCLR}, 32'd1);
    chk("bad_ERR_sticky", {31'd0, bus.ERR}, 32'd1);
  endtask

  initial begin
    CLR        = 1'b0;
    bus.START  = 1'b0;
    bus.SDI    = 1'b0;
    bus.SVALID = 1'b0;
    bus.ACK    = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk_reset_outputs("reset");
    CLR = 1'b1;
    @(posedge CLK); #1;

    // Nominal read, back-to-back bits
    read_ok(12'hA59, 0, 1'b0);

    // Month 13, then day 0
    read_bad(12'hBB9);
    read_bad(12'h020);

    // Next START clears ERR; stall after 5 bits to force the timeout
    pulse_start();
    @(negedge CLK);
    chk("restart_ERR", {31'd0, bus.ERR}, 32'd0);
    sb.push_back('{kind: 1, word: 12'h016, err: 1'b1});
    @(posedge CLK); #1;
    send_bits(12'b10110_0000000, 5, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      chk("timeout_pre_ERR", {31'd0, bus.ERR}, 32'd0);
    end
    @(negedge CLK);
    chk("timeout_ERR", {31'd0, bus.ERR}, 32'd1);
    chk("timeout_RCLR", {31'd0, bus.RCLR}, 32'd0);
    chk("timeout_CNT", {28'd0, bus.CNT}, 32'd5);
    repeat (3) @(negedge CLK);
    chk("timeout_CNT_frozen", {28'd0, bus.CNT}, 32'd5);
    chk("timeout_BUSY", {31'd0, bus.BUSY}, 32'd0);
    chk("timeout_ERR_sticky", {31'd0, bus.ERR}, 32'd1);
    @(posedge CLK); #1;

    // Asynchronous clear mid-shift, then a fresh read
    pulse_start();
    send_bits(12'hA59, 6, 0);
    #2;
    CLR = 1'b0;
    #1;
    chk_reset_outputs("async_clr");
    @(negedge CLK);
    CLR = 1'b1;
    @(posedge CLK); #1;
    read_ok(12'hA59, 0, 1'b0);

    // ACK with START together, then gapped strobes
    read_ok(12'hA59, 0, 1'b1);
    read_ok(12'hA59, 2, 1'b0);

    repeat (3) @(negedge CLK);
    chk("sb_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
